// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel frame engine.
//   mode_e  : output mode selected at frame start
//   state_e : frame sequencing FSM states
//   GRAD_W  : signed gradient width for the default 8-bit pixel
//   sat_pix : clamp an unsigned value to the largest pixel code
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'b00,
    MODE_MAG  = 2'b01,
    MODE_GX   = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    FIN   = 2'b11
  } state_e;

  // A 3x3 Sobel sum of PIX_W-bit pixels spans +/-4*(2**PIX_W-1), which
  // needs three extra bits including the sign.
  localparam int GRAD_GUARD    = 3;
  localparam int PIX_W_DEFAULT = 8;
  localparam int GRAD_W        = PIX_W_DEFAULT + GRAD_GUARD;

  function automatic logic [31:0] sat_pix(input logic [31:0] v, input int pix_w);
    logic [31:0] lim;
    lim = (32'd1 << pix_w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-length pixel delay line: o_DATA is the pixel pushed DEPTH
// enables ago. Implemented as a circular buffer read-before-write at
// the same pointer, so storage needs no reset.
//   i_CLK, i_RSTn : clock, synchronous active-low reset (pointer only)
//   i_EN          : push i_DATA and advance
//   i_DATA        : incoming pixel
//   o_DATA        : pixel delayed by DEPTH pushes
module sobel_line_buffer #(
  parameter int DEPTH = 320,
  parameter int PIX_W = 8
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic             i_EN,
  input  logic [PIX_W-1:0] i_DATA,
  output logic [PIX_W-1:0] o_DATA
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  assign o_DATA = r_mem[r_ptr];

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      r_ptr <= '0;
    end else if (i_EN) begin
      r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_EN) begin
      r_mem[r_ptr] <= i_DATA;
    end
  end

endmodule

// File: rtl/sobel_frame_engine.sv
// Gray-to-Sobel frame engine. Streams a gray frame out of a BRAM in
// raster order, builds 3x3 windows with two line buffers and writes one
// output pixel per frame address (borders included) to a second BRAM.
//   i_CLK, i_RSTn        : clock, synchronous active-low reset
//   i_START              : start pulse, accepted only in IDLE
//   i_THRESHOLD, i_MODE  : squared-magnitude threshold / output mode, latched at start
//   o_BUSY, o_DONE       : frame in progress / one-cycle completion pulse
//   o_RD_EN, o_RD_ADDR   : gray BRAM read port (data i_RD_DATA one cycle later)
//   o_WR_EN, o_WR_ADDR, o_WR_DATA : Sobel BRAM write port
module sobel_frame_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17,
  parameter int THR_W  = 18
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  input  logic              i_START,
  input  logic [THR_W-1:0]  i_THRESHOLD,
  input  logic [1:0]        i_MODE,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_RD_EN,
  output logic [ADDR_W-1:0] o_RD_ADDR,
  input  logic [PIX_W-1:0]  i_RD_DATA,
  output logic              o_WR_EN,
  output logic [ADDR_W-1:0] o_WR_ADDR,
  output logic [PIX_W-1:0]  o_WR_DATA
);

  localparam int N     = IMG_W * IMG_H;
  localparam int G_W   = PIX_W + GRAD_GUARD;
  localparam int SQ_W  = 2 * G_W;
  localparam int CMP_W = (SQ_W > THR_W) ? SQ_W : THR_W;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int FW    = $clog2(IMG_W + 1);
  localparam int WW    = $clog2(IMG_W + 2);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'(IMG_W);
  localparam logic [WW-1:0]     WARM_FULL  = WW'(IMG_W + 1);

  function automatic logic signed [G_W-1:0] ext_pix(input logic [PIX_W-1:0] p);
    return $signed({{GRAD_GUARD{1'b0}}, p});
  endfunction

  // Control state
  state_e              r_state, w_state_nxt;
  mode_e               r_mode;
  logic [THR_W-1:0]    r_thr;
  logic                r_busy, r_done;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [FW-1:0]       r_fcnt;
  logic                r_src_vld, r_src_zero;
  logic [WW-1:0]       r_warm;
  logic [ADDR_W-1:0]   r_kaddr;
  logic [CW-1:0]       r_kcol;
  logic [RW-1:0]       r_krow;
  logic                vld_p0, vld_p1;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [PIX_W-1:0]    r_wr_data;

  // Datapath
  logic [PIX_W-1:0]        r_win_p0 [3][3];
  logic [ADDR_W-1:0]       addr_p0, addr_p1;
  logic                    border_p0, border_p1;
  logic signed [G_W-1:0]   gx_p1, gy_p1;
  logic [PIX_W-1:0]        ctr_p1;

  logic [PIX_W-1:0]        w_pix, w_tap1, w_tap2;
  logic                    w_start, w_last_wr, w_win_vld, w_border;
  logic signed [G_W-1:0]   w_gx, w_gy;
  logic [G_W-1:0]          w_ax, w_ay;
  logic [G_W:0]            w_sum;
  logic [SQ_W-1:0]         w_sq;
  logic [PIX_W-1:0]        w_out;

  assign w_start   = (r_state == IDLE) && i_START;
  assign w_last_wr = (r_state == FIN) && r_wr_en && (r_wr_addr == ADDR_LAST);
  // Window centred at k is complete once W+1 pixels precede the newest one.
  assign w_win_vld = r_src_vld && (r_warm == WARM_FULL);
  assign w_border  = (r_krow == '0) || (r_krow == ROW_LAST) ||
                     (r_kcol == '0) || (r_kcol == COL_LAST);
  // Flush cycles feed zeros; those only reach windows centred on the border.
  assign w_pix     = r_src_zero ? '0 : i_RD_DATA;

  sobel_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb_row1 (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .i_EN   (r_src_vld),
    .i_DATA (w_pix),
    .o_DATA (w_tap1)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb_row2 (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .i_EN   (r_src_vld),
    .i_DATA (w_tap1),
    .o_DATA (w_tap2)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_RD_EN     = 1'b0;
    o_RD_ADDR   = '0;
    case (r_state)
      IDLE:  if (i_START) w_state_nxt = RUN;
      RUN: begin
        o_RD_EN   = 1'b1;
        o_RD_ADDR = r_rd_addr;
        if (r_rd_addr == ADDR_LAST) w_state_nxt = FLUSH;
      end
      FLUSH: if (r_fcnt == FLUSH_LAST) w_state_nxt = FIN;
      FIN:   if (r_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      r_state    <= IDLE;
      r_mode     <= MODE_BIN;
      r_thr      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_addr  <= '0;
      r_fcnt     <= '0;
      r_src_vld  <= 1'b0;
      r_src_zero <= 1'b0;
      r_warm     <= '0;
      r_kaddr    <= '0;
      r_kcol     <= '0;
      r_krow     <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last_wr;
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_last_wr) begin
        r_busy <= 1'b0;
      end
      if (w_start) begin
        r_mode    <= mode_e'(i_MODE);
        r_thr     <= i_THRESHOLD;
        r_rd_addr <= '0;
        r_fcnt    <= '0;
        r_warm    <= '0;
        r_kaddr   <= '0;
        r_kcol    <= '0;
        r_krow    <= '0;
      end else begin
        if (r_state == RUN)   r_rd_addr <= r_rd_addr + 1'b1;
        if (r_state == FLUSH) r_fcnt    <= r_fcnt + 1'b1;
        if (r_src_vld && (r_warm != WARM_FULL)) r_warm <= r_warm + 1'b1;
        if (w_win_vld) begin
          r_kaddr <= r_kaddr + 1'b1;
          if (r_kcol == COL_LAST) begin
            r_kcol <= '0;
            r_krow <= r_krow + 1'b1;
          end else begin
            r_kcol <= r_kcol + 1'b1;
          end
        end
      end
      r_src_vld  <= (r_state == RUN) || (r_state == FLUSH);
      r_src_zero <= (r_state == FLUSH);
      vld_p0     <= w_win_vld;
      vld_p1     <= vld_p0;
      r_wr_en    <= vld_p1;
      if (vld_p1) begin
        r_wr_addr <= addr_p1;
        r_wr_data <= w_out;
      end
    end
  end

  // ---- p0: 3x3 window, newest column on the right ----
  always_ff @(posedge i_CLK) begin
    if (r_src_vld) begin
      for (int r = 0; r < 3; r++) begin
        r_win_p0[r][0] <= r_win_p0[r][1];
        r_win_p0[r][1] <= r_win_p0[r][2];
      end
      r_win_p0[0][2] <= w_tap2;
      r_win_p0[1][2] <= w_tap1;
      r_win_p0[2][2] <= w_pix;
      addr_p0        <= r_kaddr;
      border_p0      <= w_border;
    end
  end

  assign w_gx = (ext_pix(r_win_p0[0][2]) + (ext_pix(r_win_p0[1][2]) <<< 1) + ext_pix(r_win_p0[2][2]))
              - (ext_pix(r_win_p0[0][0]) + (ext_pix(r_win_p0[1][0]) <<< 1) + ext_pix(r_win_p0[2][0]));
  assign w_gy = (ext_pix(r_win_p0[2][0]) + (ext_pix(r_win_p0[2][1]) <<< 1) + ext_pix(r_win_p0[2][2]))
              - (ext_pix(r_win_p0[0][0]) + (ext_pix(r_win_p0[0][1]) <<< 1) + ext_pix(r_win_p0[0][2]));

  // ---- p1: gradients ----
  always_ff @(posedge i_CLK) begin
    gx_p1     <= w_gx;
    gy_p1     <= w_gy;
    ctr_p1    <= r_win_p0[1][1];
    addr_p1   <= addr_p0;
    border_p1 <= border_p0;
  end

  assign w_ax  = gx_p1[G_W-1] ? $unsigned(-gx_p1) : $unsigned(gx_p1);
  assign w_ay  = gy_p1[G_W-1] ? $unsigned(-gy_p1) : $unsigned(gy_p1);
  assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_sq  = SQ_W'(w_ax) * SQ_W'(w_ax) + SQ_W'(w_ay) * SQ_W'(w_ay);

  always_comb begin
    w_out = '0;
    if (border_p1) begin
      w_out = (r_mode == MODE_PASS) ? ctr_p1 : '0;
    end else begin
      case (r_mode)
        MODE_BIN:  w_out = (CMP_W'(w_sq) > CMP_W'(r_thr)) ? '1 : '0;
        MODE_MAG:  w_out = PIX_W'(sat_pix(32'(w_sum), PIX_W));
        MODE_GX:   w_out = PIX_W'(sat_pix(32'(w_ax), PIX_W));
        MODE_PASS: w_out = ctr_p1;
        default:   w_out = '0;
      endcase
    end
  end

  // ---- p2: registered write port ----
  assign o_WR_EN   = r_wr_en;
  assign o_WR_ADDR = r_wr_addr;
  assign o_WR_DATA = r_wr_data;
  assign o_BUSY    = r_busy;
  assign o_DONE    = r_done;

endmodule

// File: tb/tb_sobel_frame_engine.sv
module tb_sobel_frame_engine;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [17:0] thr = '0;
  logic [1:0]  mode = 2'b00;
  logic        busy, done, rd_en, wr_en;
  logic [16:0] rd_addr, wr_addr;
  logic [7:0]  rd_data = '0;
  logic [7:0]  wr_data;

  sobel_frame_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(17), .THR_W(18)) dut (
    .i_CLK       (clk),
    .i_RSTn      (rstn),
    .i_START     (start),
    .i_THRESHOLD (thr),
    .i_MODE      (mode),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_RD_EN     (rd_en),
    .o_RD_ADDR   (rd_addr),
    .i_RD_DATA   (rd_data),
    .o_WR_EN     (wr_en),
    .o_WR_ADDR   (wr_addr),
    .o_WR_DATA   (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [64];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0;
  int wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
  bit exp_done = 0, lat_on = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic fail(input string name, input string why);
    n_chk++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Gray BRAM with one cycle of read latency; t0 is the cycle carrying index 0.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd_en) begin
      rd_data <= mem[rd_addr[5:0]];
      if (rd_addr == 17'd0) t0 = cyc;
    end
  end

  // Monitor: compare every write and every done pulse with the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en) begin
        exp_t e;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          fail("wr_unexpected", $sformatf("write to addr %0d data %0d with nothing expected", wr_addr, wr_data));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk($sformatf("wr_data@%0d", e.a), wr_data, e.d);
          if (lat_on) chk($sformatf("latency@%0d", e.a), cyc, t0 + int'(e.a) + W + 1 + 3);
        end
      end
      if (done) begin
        done_cnt++;
        if (!exp_done) begin
          fail("done_unexpected", "o_DONE pulsed with no frame expected");
        end else begin
          chk("busy_at_done", busy, 0);
          chk("done_after_last_wr", last_wr_cyc, cyc - 1);
          chk("writes_per_frame", wr_cnt, N);
        end
      end
    end
  end

  // kind 0 flat 50, 1 step 0/255, 2 step 0/10, 3 ramp
  task automatic load(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: mem[i] = 8'd50;
        1: mem[i] = ((i % W) >= 4) ? 8'd255 : 8'd0;
        2: mem[i] = ((i % W) >= 4) ? 8'd10 : 8'd0;
        default: mem[i] = 8'(i);
      endcase
    end
  endtask

  // kind 0 all zero, 1 interior cols 3/4 = 255, 2 data = address
  task automatic push_exp(input int kind);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      int r, c;
      r = k / W;
      c = k % W;
      e.a = 17'(k);
      case (kind)
        0: e.d = 8'd0;
        1: e.d = (r > 0 && r < H - 1 && (c == 3 || c == 4)) ? 8'd255 : 8'd0;
        default: e.d = 8'(k);
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [17:0] t);
    wr_cnt   = 0;
    exp_done = 1;
    @(negedge clk); #1;
    mode  = m;
    thr   = t;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_writes(input int n);
    int i;
    i = 0;
    while (wr_cnt < n && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    if (wr_cnt < n) fail("write_timeout", $sformatf("only %0d of %0d writes", wr_cnt, n));
  endtask

  task automatic finish_frame(input string name);
    int d0, i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    if (done_cnt == d0) fail({name, "_done_timeout"}, "no o_DONE");
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_single_done"}, done_cnt, d0 + 1);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_rd_en"}, rd_en, 0);
    chk({name, "_idle_wr_en"}, wr_en, 0);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
    exp_done = 0;
    lat_on   = 0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_rd_en"}, rd_en, 0);
    chk({name, "_rd_addr"}, rd_addr, 0);
    chk({name, "_wr_en"}, wr_en, 0);
    chk({name, "_wr_addr"}, wr_addr, 0);
    chk({name, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: flat frame, binary, threshold 0
    load(0); push_exp(0);
    start_frame(2'b00, 18'd0);
    finish_frame("flat");

    // 2: 0/255 step, magnitude, saturates at the edge columns
    load(1); push_exp(1);
    start_frame(2'b01, 18'd0);
    finish_frame("step_mag");

    // 3: 0/10 step, SQ = 1600 at the edge columns
    load(2); push_exp(1);
    start_frame(2'b00, 18'd1599);
    finish_frame("thr1599");
    load(2); push_exp(0);
    start_frame(2'b00, 18'd1600);
    finish_frame("thr1600");

    // 4: ramp, pass-through, latency checked per write
    load(3); push_exp(2);
    lat_on = 1;
    start_frame(2'b11, 18'd0);
    finish_frame("ramp_pass");

    // 5: inputs disturbed mid-frame must not affect the latched frame
    load(1); push_exp(1);
    start_frame(2'b01, 18'd0);
    wait_writes(10);
    mode  = 2'b00;
    thr   = 18'd0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_mid_frame", busy, 1);
    finish_frame("disturbed");

    // 6: reset at write 20 aborts the frame without o_DONE
    load(3); push_exp(2);
    start_frame(2'b11, 18'd0);
    wait_writes(20);
    exp_done = 0;
    rstn = 1'b0;
    @(negedge clk); #1;
    chk_all_zero("abort");
    exp_q.delete();
    d0 = done_cnt;
    rstn = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle_busy", busy, 0);

    load(3); push_exp(2);
    start_frame(2'b11, 18'd0);
    finish_frame("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
